stream_decipher: RTL and testbench

- Receive-side counterpart of the stream_cypher encrypt path. It regenerates the same LFSR keystream from a shared 16-bit key and XORs it with incoming ciphertext bytes to recover plaintext.
- Framed: each frame starts on a start-of-frame strobe that reseeds the keystream.
- Valid/ready handshake on both sides, with one registered output stage.

---
 rtl/stream_decipher.sv | 149 ++++++++++++++
 tb/tb_stream_decipher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_decipher.sv
// Framed LFSR stream decipher: regenerates the keystream from a 16-bit key and XORs it with
// incoming ciphertext. Valid/ready on both sides with a single registered output stage.
module stream_decipher #(
  parameter int unsigned FRAME_LEN = 16,
  parameter logic [15:0] ZERO_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       key_load,
  input  logic [7:0] key_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_eof,
  output logic       locked,
  output logic       drop
);

  localparam logic [15:0] LfsrMask  = 16'hB400;
  localparam logic [7:0]  FrameLenB = 8'(FRAME_LEN);

  typedef enum logic [1:0] {StNoKey, StKeyed, StStream} state_e;

  state_e      state_q, state_d;
  logic [15:0] key_q, key_d;
  logic        kptr_q, kptr_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_eof_q, out_eof_d;
  logic        drop_q, drop_d;

  logic        accept;
  logic        take;
  logic [15:0] seed;
  logic [15:0] base;
  logic [7:0]  cnt_inc;

  // Eight single-bit Galois steps (right shift) per accepted byte.
  function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ LfsrMask) : (r >> 1);
    end
    return r;
  endfunction

  assign seed     = (key_q == 16'h0000) ? ZERO_SEED : key_q;
  // key_load blocks acceptance so a key reload never races a data byte.
  assign in_ready = ena & ~key_load & (state_q != StNoKey) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    kptr_d      = kptr_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eof_d   = out_eof_q;
    drop_d      = 1'b0;
    take        = 1'b0;
    base        = seed;
    cnt_inc     = 8'd1;

    if (ena) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end

      if (key_load) begin
        if (state_q == StNoKey && kptr_q) begin
          key_d[15:8] = key_in;
          kptr_d      = 1'b0;
          state_d     = StKeyed;
        end else begin
          key_d[7:0] = key_in;
          kptr_d     = 1'b1;
          state_d    = StNoKey;
          cnt_d      = 8'd0;
        end
      end else if (accept) begin
        if (in_sof) begin
          take = 1'b1;
        end else if (state_q == StStream) begin
          take    = 1'b1;
          base    = lfsr_q;
          cnt_inc = cnt_q + 8'd1;
        end else begin
          drop_d = 1'b1;
        end
      end

      if (take) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data ^ base[7:0];
        lfsr_d      = lfsr_step8(base);
        if (cnt_inc == FrameLenB) begin
          out_eof_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = StKeyed;
        end else begin
          out_eof_d = 1'b0;
          cnt_d     = cnt_inc;
          state_d   = StStream;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StNoKey;
      key_q       <= 16'h0000;
      kptr_q      <= 1'b0;
      lfsr_q      <= 16'h0000;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_eof_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      kptr_q      <= kptr_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eof_q   <= out_eof_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eof   = out_eof_q;
  assign drop      = drop_q;
  assign locked    = (state_q == StStream);

endmodule

// File: tb/tb_stream_decipher.sv
// Directed bench for stream_decipher: table-driven frame plus hand-written handshake,
// resync, key reload and reset sequences. A second instance covers FRAME_LEN=1.
module tb_stream_decipher;

  logic       clk = 1'b0;
  logic       rst, ena, key_load, in_valid, in_sof, out_ready;
  logic [7:0] key_in, in_data;
  logic       in_ready, out_valid, out_eof, locked, drop;
  logic [7:0] out_data;
  logic       in_ready1, out_valid1, out_eof1, locked1, drop1;
  logic [7:0] out_data1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sof;
    logic [7:0] cdata;
    logic [7:0] exp_data;
    logic       exp_eof;
    logic       exp_locked;
  } vec_t;

  vec_t vecs[16];

  stream_decipher dut (
    .clk(clk), .rst(rst), .ena(ena), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eof(out_eof),
    .locked(locked), .drop(drop)
  );

  stream_decipher #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready1), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_eof(out_eof1),
    .locked(locked1), .drop(drop1)
  );

  always #5 clk = ~clk;

  // Reference keystream byte k of a frame seeded with 'seed'.
  function automatic logic [7:0] ks_at(input logic [15:0] seed, input int k);
    logic [15:0] s;
    s = seed;
    for (int n = 0; n < 8 * k; n++) begin
      s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    end
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [7:0] lo, input logic [7:0] hi);
    key_load = 1'b1;
    key_in   = lo;
    tick();
    key_in   = hi;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send(input logic sof, input logic [7:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h34, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h33, 8'h01, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h6C, 8'h02, 1'b0, 1'b1};
    for (int i = 3; i < 16; i++) begin
      vecs[i] = '{1'b0, 8'(i) ^ ks_at(16'h1234, i), 8'(i), (i == 15), (i != 15)};
    end

    rst = 1'b1; ena = 1'b1; key_load = 1'b0; key_in = 8'h00;
    in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", 16'(out_data), 16'h0);
    chk("rst_out_eof", 16'(out_eof), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_drop", 16'(drop), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b0;

    // First SOF byte after key load.
    load_key(8'h34, 8'h12);
    in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h5A;
    #1;
    chk("keyed_in_ready", 16'(in_ready), 16'h1);
    tick();
    chk("sof_out_valid", 16'(out_valid), 16'h1);
    chk("sof_out_data", 16'(out_data), 16'h6E);
    chk("sof_locked", 16'(locked), 16'h1);
    chk("sof_out_eof", 16'(out_eof), 16'h0);
    chk("len1_out_data", 16'(out_data1), 16'h6E);
    chk("len1_out_eof", 16'(out_eof1), 16'h1);
    chk("len1_locked", 16'(locked1), 16'h0);

    // Full frame of plaintext 0x00..0x0F (SOF resyncs the one-byte frame above).
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].sof, vecs[i].cdata);
      chk($sformatf("frm_valid_%0d", i), 16'(out_valid), 16'h1);
      chk($sformatf("frm_data_%0d", i), 16'(out_data), 16'(vecs[i].exp_data));
      chk($sformatf("frm_eof_%0d", i), 16'(out_eof), 16'(vecs[i].exp_eof));
      chk($sformatf("frm_locked_%0d", i), 16'(locked), 16'(vecs[i].exp_locked));
    end
    in_valid = 1'b0;
    tick();
    chk("frm_idle_valid", 16'(out_valid), 16'h0);
    chk("frm_idle_locked", 16'(locked), 16'h0);

    // Resync at cnt=5: SOF 0x5A again restarts the keystream and count.
    send(1'b1, 8'h5A);
    chk("rs_first", 16'(out_data), 16'h6E);
    for (int k = 1; k < 5; k++) begin
      send(1'b0, 8'(8'hA0 + k) ^ ks_at(16'h1234, k));
      chk($sformatf("rs_pre_%0d", k), 16'(out_data), 16'(8'hA0 + k));
    end
    send(1'b1, 8'h5A);
    chk("rs_resync_data", 16'(out_data), 16'h6E);
    chk("rs_resync_eof", 16'(out_eof), 16'h0);
    chk("rs_resync_locked", 16'(locked), 16'h1);
    for (int k = 1; k < 16; k++) begin
      send(1'b0, 8'(8'hB0 + k) ^ ks_at(16'h1234, k));
      chk($sformatf("rs_data_%0d", k), 16'(out_data), 16'(8'hB0 + k));
      chk($sformatf("rs_eof_%0d", k), 16'(out_eof), 16'(k == 15));
    end
    in_valid = 1'b0;

    // Zero key falls back to ZERO_SEED; non-SOF byte in KEYED is dropped.
    key_load = 1'b1; key_in = 8'h00;
    #1;
    chk("kl_in_ready", 16'(in_ready), 16'h0);
    tick();
    chk("kl_locked", 16'(locked), 16'h0);
    #1;
    chk("nokey_in_ready", 16'(in_ready), 16'h0);
    tick();
    key_load = 1'b0;
    send(1'b0, 8'h77);
    chk("drop_pulse", 16'(drop), 16'h1);
    chk("drop_no_valid", 16'(out_valid), 16'h0);
    send(1'b1, 8'h00);
    chk("drop_cleared", 16'(drop), 16'h0);
    chk("zero_seed_data", 16'(out_data), 16'hE1);
    chk("zero_seed_valid", 16'(out_valid), 16'h1);
    in_valid = 1'b0;
    tick();

    // Backpressure: byte held stable, next byte waits, nothing lost or duplicated.
    load_key(8'h34, 8'h12);
    out_ready = 1'b0;
    send(1'b1, 8'h10 ^ ks_at(16'h1234, 0));
    chk("bp_valid0", 16'(out_valid), 16'h1);
    chk("bp_data0", 16'(out_data), 16'h10);
    in_data = 8'h11 ^ ks_at(16'h1234, 1);
    in_sof  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", c), 16'(in_ready), 16'h0);
      tick();
      chk($sformatf("bp_hold_%0d", c), 16'(out_data), 16'h10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 16'(in_ready), 16'h1);
    tick();
    chk("bp_data1", 16'(out_data), 16'h11);
    send(1'b0, 8'h12 ^ ks_at(16'h1234, 2));
    chk("bp_data2", 16'(out_data), 16'h12);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", 16'(out_valid), 16'h0);

    // key_load wins over a simultaneous accept.
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h55;
    key_load = 1'b1; key_in = 8'h34;
    #1;
    chk("klacc_in_ready", 16'(in_ready), 16'h0);
    tick();
    chk("klacc_valid", 16'(out_valid), 16'h0);
    chk("klacc_drop", 16'(drop), 16'h0);
    chk("klacc_locked", 16'(locked), 16'h0);
    key_in = 8'h12;
    in_valid = 1'b0;
    tick();
    key_load = 1'b0;

    // Reset mid-frame with a held output byte.
    out_ready = 1'b0;
    send(1'b1, 8'h5A);
    chk("pre_rst_valid", 16'(out_valid), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_data", 16'(out_data), 16'h0);
    chk("mid_rst_locked", 16'(locked), 16'h0);
    #1;
    chk("mid_rst_in_ready", 16'(in_ready), 16'h0);
    key_load = 1'b1; key_in = 8'h34;
    tick();
    key_load = 1'b0;
    #1;
    chk("one_strobe_in_ready", 16'(in_ready), 16'h0);
    key_load = 1'b1; key_in = 8'h12;
    tick();
    key_load = 1'b0;
    #1;
    chk("two_strobe_in_ready", 16'(in_ready), 16'h1);
    tick();
    chk("post_rst_data", 16'(out_data), 16'h6E);

    // ena=0 freezes everything, including the output register.
    ena = 1'b0; out_ready = 1'b1; in_sof = 1'b0;
    #1;
    chk("ena0_in_ready", 16'(in_ready), 16'h0);
    tick();
    chk("ena0_hold_valid", 16'(out_valid), 16'h1);
    chk("ena0_hold_data", 16'(out_data), 16'h6E);
    ena = 1'b1; in_valid = 1'b0;
    tick();
    chk("ena1_drain", 16'(out_valid), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
